decode_sequencer: RTL and testbench
===================================

Name: decode_sequencer

Overview:
- Stage directly downstream of the fetch unit. Consumes the 9-bit instruction word and sequences the fetch unit's control pins: init, fetch_unit_en, branch, branchi, jump, target, immediate.
- Latches each instruction into an instruction register (IR), decodes it, and stalls on memory operations.
- Issues exactly one PC-advance pulse per retired instruction, and stops on HALT.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles spent in MEM waiting for mem_ack before the error abort.
- ADDR_W, 8: PC / target / start-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a program run (ignored unless state is IDLE or HALTED)
- start_addr  in  ADDR_W  first PC of the program
- inst  in  9  instruction word from the fetch unit
- cond_flag  in  1  ALU zero flag, used for conditional branches
- rs_value  in  ADDR_W  register-file read data, used as the absolute branch target
- mem_ack  in  1  memory completion
- init  out  1  one-cycle pulse to the fetch unit
- start_address  out  ADDR_W  registered copy of start_addr
- fetch_unit_en  out  1  PC-advance strobe
- branch  out  1  absolute branch
- branchi  out  1  relative branch
- jump  out  1  selects the 6-bit relative form
- target  out  ADDR_W  absolute branch target
- immediate  out  6  relative offset, sign-magnitude
- opcode  out  3  IR[8:6]
- rd  out  3  IR[5:3]
- rs  out  3  IR[2:0]
- reg_we  out  1  register write strobe
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- busy  out  1  state is not IDLE and not HALTED
- done  out  1  halted normally
- err  out  1  memory timeout
- retired_count  out  16  retired-instruction counter (see Optional Feature)

Behaviour:
- Reset: state=IDLE; IR=0; all outputs 0. Reset mid-run aborts immediately with no further strobes.
- All outputs are registered.
- Decode of the IR (op = IR[8:6]):
  - 000 ALU: reg_we in EXEC.
  - 001 ADDI: reg_we in EXEC.
  - 010 LW: memory read, then reg_we.
  - 011 SW: memory write, mem_we=1.
  - 100 BCND: if cond_flag, branchi=1, jump=0, immediate={2'b00,IR[3:0]}.
  - 101 JMP: branchi=1, jump=1, immediate=IR[5:0].
  - 110 BR: branch=1, target=rs_value.
  - 111 HALT when IR[5:0]==0; otherwise NOP.
- States:
  - IDLE: on start, pulse init and latch start_address; go to LOAD.
  - LOAD: wait one cycle for the instruction at the new PC to settle; go to FETCH.
  - FETCH: IR<=inst; go to DECODE.
  - DECODE: drive opcode/rd/rs. LW/SW go to MEM (mem_req=1, wait counter cleared); HALT goes to HALTED with done=1; all others go to EXEC.
  - MEM: hold mem_req (and mem_we for SW) until mem_ack, then go to EXEC. If the wait counter reaches MEM_WAIT_MAX without mem_ack, set err=1 and go to HALTED.
  - EXEC: one cycle. fetch_unit_en=1 with the branch fields set as decoded (all zero means PC+1); reg_we for ALU/ADDI/LW. Go to LOAD.
  - HALTED: outputs held at 0 except done/err. start restarts the run as in IDLE and clears done/err.
- Strobe rules:
  - fetch_unit_en, init, reg_we: exactly 1 cycle each.
  - branch and branchi are never both asserted.
  - Per instruction: DECODE to fetch_unit_en is 1 cycle for non-memory instructions; for memory instructions it is the mem_ack cycle + 1.
- BCND with cond_flag=0: plain increment (branchi=0). cond_flag is sampled in DECODE.
- mem_ack is ignored outside MEM. mem_ack arriving in the same cycle as the timeout wins (no err).
- start while busy is ignored.

Optional Feature:
- Macro: DECODE_RETIRE_COUNT_EN.
- Defined: retired_count increments on every EXEC cycle and on HALT entry. It wraps at 16'hFFFF to 0, and clears on reset and on start.
- Undefined: retired_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then start with start_addr=8'h10 -> init high exactly 1 cycle; start_address=8'h10; FETCH two cycles later.
- inst=9'b001_010_011 (ADDI) -> in EXEC: fetch_unit_en=1, reg_we=1, branch=branchi=0, rd=3'd2, rs=3'd3.
- inst=9'b100_001_101 (BCND, IR[3:0]=4'b1101) with cond_flag=1 -> branchi=1, jump=0, immediate=6'b001101. Same instruction with cond_flag=0 -> branchi=0, fetch_unit_en=1.
- inst=9'b010_001_010 (LW), mem_ack after 3 cycles -> mem_req held for 3 cycles; fetch_unit_en 1 cycle after ack; reg_we=1. Repeat with no ack -> err=1 after MEM_WAIT_MAX=15 cycles, state HALTED, no fetch_unit_en.
- inst=9'b110_000_000 (BR) with rs_value=8'h42 -> branch=1, target=8'h42. Then inst=9'b111_000_000 (HALT) -> done=1, busy=0, no further strobes. With DECODE_RETIRE_COUNT_EN defined, retired_count=2 when counting from the BR.
- Assert reset while in MEM -> next cycle state=IDLE, mem_req=0, all outputs 0.

Source files
------------

// File: rtl/decode_sequencer.sv
// decode_sequencer
//
// Purpose:
//   Sits directly downstream of the fetch unit. Latches each 9-bit instruction
//   into an instruction register, decodes it, stalls on memory operations and
//   drives the fetch unit's control pins so that exactly one PC-advance strobe
//   is issued per retired instruction. A HALT instruction stops the run.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, start_addr   begin a run at start_addr (accepted in IDLE/HALTED only)
//   inst                instruction word from the fetch unit
//   cond_flag           ALU zero flag for conditional branches (sampled in DECODE)
//   rs_value            register read data, absolute branch target
//   mem_ack             memory completion (only looked at in MEM)
//   init                one-cycle pulse to the fetch unit at run start
//   start_address       registered copy of start_addr
//   fetch_unit_en       PC-advance strobe, one per retired instruction
//   branch / branchi    absolute / relative branch select (mutually exclusive)
//   jump                selects the 6-bit relative form
//   target, immediate   absolute target / sign-magnitude relative offset
//   opcode, rd, rs      IR fields
//   reg_we              register write strobe
//   mem_req, mem_we     memory request / write
//   busy, done, err     run status
//   retired_count       retired-instruction counter
//
// Build option:
//   DECODE_RETIRE_COUNT_EN - when defined, retired_count counts every EXEC cycle
//   and the HALT entry (wraps, cleared on reset and start). When undefined the
//   output is tied to zero and no counter is built.
//
// Every output is driven straight from a register; the combinational process
// computes the value each register takes for the state being entered.

module decode_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [8:0]        inst,
    input  logic              cond_flag,
    input  logic [ADDR_W-1:0] rs_value,
    input  logic              mem_ack,
    output logic              init,
    output logic [ADDR_W-1:0] start_address,
    output logic              fetch_unit_en,
    output logic              branch,
    output logic              branchi,
    output logic              jump,
    output logic [ADDR_W-1:0] target,
    output logic [5:0]        immediate,
    output logic [2:0]        opcode,
    output logic [2:0]        rd,
    output logic [2:0]        rs,
    output logic              reg_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       retired_count
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BCND = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_BR   = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALTED
    } state_t;

    state_t              r_state, w_state_next;
    logic [8:0]          r_ir, w_ir_next;
    logic [WAIT_W-1:0]   r_wait, w_wait_next;
    logic                r_init, w_init_next;
    logic [ADDR_W-1:0]   r_start_address, w_start_address_next;
    logic                r_fue, w_fue_next;
    logic                r_branch, w_branch_next;
    logic                r_branchi, w_branchi_next;
    logic                r_jump, w_jump_next;
    logic [ADDR_W-1:0]   r_target, w_target_next;
    logic [5:0]          r_imm, w_imm_next;
    logic [2:0]          r_opcode, w_opcode_next;
    logic [2:0]          r_rd, w_rd_next;
    logic [2:0]          r_rs, w_rs_next;
    logic                r_reg_we, w_reg_we_next;
    logic                r_mem_req, w_mem_req_next;
    logic                r_mem_we, w_mem_we_next;
    logic                r_busy, w_busy_next;
    logic                r_done, w_done_next;
    logic                r_err, w_err_next;

    logic w_start_go;   // start accepted this cycle
    logic w_halt_go;    // HALT decoded this cycle

    assign w_start_go = start && (r_state == S_IDLE || r_state == S_HALTED);
    assign w_halt_go  = (r_state == S_DECODE) && (r_ir == 9'b111_000_000);

    always_comb begin
        w_state_next         = r_state;
        w_ir_next            = r_ir;
        w_wait_next          = r_wait;
        w_init_next          = 1'b0;
        w_start_address_next = r_start_address;
        w_fue_next           = 1'b0;
        w_branch_next        = 1'b0;
        w_branchi_next       = 1'b0;
        w_jump_next          = 1'b0;
        w_target_next        = '0;
        w_imm_next           = '0;
        w_opcode_next        = r_opcode;
        w_rd_next            = r_rd;
        w_rs_next            = r_rs;
        w_reg_we_next        = 1'b0;
        w_mem_req_next       = 1'b0;
        w_mem_we_next        = 1'b0;
        w_done_next          = r_done;
        w_err_next           = r_err;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (w_start_go) begin
                    w_state_next         = S_LOAD;
                    w_init_next          = 1'b1;
                    w_start_address_next = start_addr;
                    w_done_next          = 1'b0;
                    w_err_next           = 1'b0;
                end
            end
            S_LOAD: w_state_next = S_FETCH;
            S_FETCH: begin
                w_ir_next     = inst;
                w_opcode_next = inst[8:6];
                w_rd_next     = inst[5:3];
                w_rs_next     = inst[2:0];
                w_state_next  = S_DECODE;
            end
            S_DECODE: begin
                if (r_ir[8:6] == OP_LW || r_ir[8:6] == OP_SW) begin
                    w_state_next   = S_MEM;
                    w_mem_req_next = 1'b1;
                    w_mem_we_next  = (r_ir[8:6] == OP_SW);
                    w_wait_next    = '0;
                end else if (w_halt_go) begin
                    w_state_next         = S_HALTED;
                    w_done_next          = 1'b1;
                    w_start_address_next = '0;
                    w_opcode_next        = '0;
                    w_rd_next            = '0;
                    w_rs_next            = '0;
                end else begin
                    // Non-memory instruction retires next cycle; zero branch
                    // fields tell the fetch unit to simply increment the PC.
                    w_state_next  = S_EXEC;
                    w_fue_next    = 1'b1;
                    w_reg_we_next = (r_ir[8:6] == OP_ALU) || (r_ir[8:6] == OP_ADDI);
                    case (r_ir[8:6])
                        OP_BCND: begin
                            if (cond_flag) begin
                                w_branchi_next = 1'b1;
                                w_imm_next     = {2'b00, r_ir[3:0]};
                            end
                        end
                        OP_JMP: begin
                            w_branchi_next = 1'b1;
                            w_jump_next    = 1'b1;
                            w_imm_next     = r_ir[5:0];
                        end
                        OP_BR: begin
                            w_branch_next = 1'b1;
                            w_target_next = rs_value;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                // An ack on the final wait cycle takes priority over timeout.
                if (mem_ack) begin
                    w_state_next  = S_EXEC;
                    w_fue_next    = 1'b1;
                    w_reg_we_next = (r_ir[8:6] == OP_LW);
                end else if (r_wait == WAIT_W'(MEM_WAIT_MAX - 1)) begin
                    w_state_next         = S_HALTED;
                    w_err_next           = 1'b1;
                    w_start_address_next = '0;
                    w_opcode_next        = '0;
                    w_rd_next            = '0;
                    w_rs_next            = '0;
                end else begin
                    w_mem_req_next = 1'b1;
                    w_mem_we_next  = r_mem_we;
                    w_wait_next    = r_wait + 1'b1;
                end
            end
            S_EXEC: w_state_next = S_LOAD;
            default: w_state_next = S_IDLE;
        endcase

        w_busy_next = (w_state_next != S_IDLE) && (w_state_next != S_HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ir            <= '0;
            r_wait          <= '0;
            r_init          <= 1'b0;
            r_start_address <= '0;
            r_fue           <= 1'b0;
            r_branch        <= 1'b0;
            r_branchi       <= 1'b0;
            r_jump          <= 1'b0;
            r_target        <= '0;
            r_imm           <= '0;
            r_opcode        <= '0;
            r_rd            <= '0;
            r_rs            <= '0;
            r_reg_we        <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_ir            <= w_ir_next;
            r_wait          <= w_wait_next;
            r_init          <= w_init_next;
            r_start_address <= w_start_address_next;
            r_fue           <= w_fue_next;
            r_branch        <= w_branch_next;
            r_branchi       <= w_branchi_next;
            r_jump          <= w_jump_next;
            r_target        <= w_target_next;
            r_imm           <= w_imm_next;
            r_opcode        <= w_opcode_next;
            r_rd            <= w_rd_next;
            r_rs            <= w_rs_next;
            r_reg_we        <= w_reg_we_next;
            r_mem_req       <= w_mem_req_next;
            r_mem_we        <= w_mem_we_next;
            r_busy          <= w_busy_next;
            r_done          <= w_done_next;
            r_err           <= w_err_next;
        end
    end

`ifdef DECODE_RETIRE_COUNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk) begin
        if (reset || w_start_go) begin
            r_retired <= '0;
        end else if (r_state == S_EXEC || w_halt_go) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired_count = r_retired;
`else
    assign retired_count = 16'd0;
`endif

    assign init          = r_init;
    assign start_address = r_start_address;
    assign fetch_unit_en = r_fue;
    assign branch        = r_branch;
    assign branchi       = r_branchi;
    assign jump          = r_jump;
    assign target        = r_target;
    assign immediate     = r_imm;
    assign opcode        = r_opcode;
    assign rd            = r_rd;
    assign rs            = r_rs;
    assign reg_we        = r_reg_we;
    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer
//
// Purpose: self-checking bench for decode_sequencer. Each instruction pushes
// its expected retirement record to a scoreboard queue when it is driven; the
// record is popped and compared when the DUT raises fetch_unit_en. HALT,
// memory timeout and reset-in-MEM are checked directly.
// Ports: none (top-level bench).

module tb_decode_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, cond_flag, mem_ack;
    logic [7:0]  start_addr, rs_value;
    logic [8:0]  inst;
    logic        init, fetch_unit_en, branch, branchi, jump;
    logic        reg_we, mem_req, mem_we, busy, done, err;
    logic [7:0]  start_address, target;
    logic [5:0]  immediate;
    logic [2:0]  opcode, rd, rs;
    logic [15:0] retired_count;

    decode_sequencer #(.MEM_WAIT_MAX(15), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .inst(inst), .cond_flag(cond_flag), .rs_value(rs_value), .mem_ack(mem_ack),
        .init(init), .start_address(start_address), .fetch_unit_en(fetch_unit_en),
        .branch(branch), .branchi(branchi), .jump(jump), .target(target),
        .immediate(immediate), .opcode(opcode), .rd(rd), .rs(rs),
        .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .busy(busy),
        .done(done), .err(err), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] ins;
        logic [2:0] opcode, rd, rs;
        logic       reg_we, branch, branchi, jump, mem_we;
        logic [7:0] target;
        logic [5:0] imm;
        int         mem_cycles;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_retired = 0;
    int   cnt_en;
    logic [7:0] cur_saddr = 8'h00;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ret_exp(input int v);
        return (cnt_en != 0) ? v : 0;
    endfunction

    // Expected retirement record derived from the instruction set definition.
    function automatic exp_t model(input logic [8:0] ins, input logic c,
                                   input logic [7:0] rv, input int ack_delay);
        exp_t e;
        e.ins = ins;
        e.opcode = ins[8:6]; e.rd = ins[5:3]; e.rs = ins[2:0];
        e.reg_we = 1'b0; e.branch = 1'b0; e.branchi = 1'b0; e.jump = 1'b0;
        e.mem_we = 1'b0; e.target = 8'h00; e.imm = 6'h00; e.mem_cycles = 0;
        case (ins[8:6])
            3'b000, 3'b001: e.reg_we = 1'b1;
            3'b010: begin e.reg_we = 1'b1; e.mem_cycles = ack_delay; end
            3'b011: begin e.mem_we = 1'b1; e.mem_cycles = ack_delay; end
            3'b100: if (c) begin e.branchi = 1'b1; e.imm = {2'b00, ins[3:0]}; end
            3'b101: begin e.branchi = 1'b1; e.jump = 1'b1; e.imm = ins[5:0]; end
            3'b110: begin e.branch = 1'b1; e.target = rv; end
            default: ;
        endcase
        return e;
    endfunction

    // Drives one instruction and waits for its retirement. Called at a negedge.
    task automatic run_inst(input logic [8:0] ins, input logic c, input logic [7:0] rv,
                            input int ack_delay, input bit do_start,
                            input logic [7:0] saddr, input bit poke_start);
        exp_t e;
        int   mc = 0;
        bit   seen = 0;
        inst = ins; cond_flag = c; rs_value = rv;
        sb_q.push_back(model(ins, c, rv, ack_delay));
        if (do_start) begin
            start_addr = saddr; start = 1'b1; cur_saddr = saddr; exp_retired = 0;
        end
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (do_start && i == 1) begin
                check_val("init_pulse", init, 1);
                check_val("start_address", start_address, saddr);
                check_val("busy_run", busy, 1);
                check_val("status_cleared", {done, err}, 0);
                check_val("retired_cleared", retired_count, 0);
            end
            if (do_start && i == 2) check_val("init_one_cycle", init, 0);
            if (poke_start && i == 1) begin
                start = 1'b1; start_addr = 8'hEE;
            end
            if (poke_start && i == 2) begin
                check_val("start_ignored_init", init, 0);
                check_val("start_ignored_addr", start_address, cur_saddr);
            end
            if (mem_req) begin
                mc++;
                check_val("mem_we", mem_we, sb_q[0].mem_we);
            end
            mem_ack = (ack_delay > 0) && mem_req && (mc == ack_delay);
            if (fetch_unit_en) begin
                seen = 1;
                e = sb_q.pop_front();
                check_val("latency", i, 4 + e.mem_cycles);
                check_val("mem_cycles", mc, e.mem_cycles);
                check_val("fields", {opcode, rd, rs}, {e.opcode, e.rd, e.rs});
                check_val("reg_we", reg_we, e.reg_we);
                check_val("branch_ctl", {branch, branchi, jump}, {e.branch, e.branchi, e.jump});
                check_val("branch_excl", branch & branchi, 0);
                check_val("target", target, e.target);
                check_val("immediate", immediate, e.imm);
                check_val("retired_count", retired_count, ret_exp(exp_retired));
                exp_retired++;
                $display("[%0t] retire inst=%09b lat=%0d mem_cycles=%0d br=%b bri=%b j=%b tgt=%02h imm=%02h",
                         $time, e.ins, i, mc, branch, branchi, jump, target, immediate);
            end
        end
        mem_ack = 1'b0;
        if (!seen) begin
            check_val("retire_timeout", 0, 1);
            e = sb_q.pop_front();
        end
    endtask

    task automatic run_halt();
        bit seen = 0;
        inst = 9'b111_000_000;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (fetch_unit_en) check_val("halt_no_fue", fetch_unit_en, 0);
            if (done) begin
                seen = 1;
                check_val("halt_latency", i, 4);
                check_val("halt_busy", busy, 0);
                check_val("halt_err", err, 0);
                check_val("halt_retired", retired_count, ret_exp(exp_retired + 1));
                $display("[%0t] halt lat=%0d retired=%0d", $time, i, retired_count);
            end
        end
        if (!seen) check_val("halt_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("halted_quiet",
                      {init, fetch_unit_en, branch, branchi, jump, reg_we, mem_req, mem_we, busy,
                       opcode, rd, rs, done}, 22'd1);
        end
    endtask

    task automatic run_timeout();
        bit seen = 0;
        int mc = 0;
        inst = 9'b010_011_000;
        mem_ack = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) mc++;
            if (fetch_unit_en) check_val("timeout_no_fue", fetch_unit_en, 0);
            if (err) begin
                seen = 1;
                check_val("timeout_latency", i, 4 + 15);
                check_val("timeout_mem_cycles", mc, 15);
                check_val("timeout_state", {busy, done, mem_req}, 0);
                $display("[%0t] timeout lat=%0d mem_cycles=%0d", $time, i, mc);
            end
        end
        if (!seen) check_val("timeout_never", 0, 1);
    endtask

    initial begin
`ifdef DECODE_RETIRE_COUNT_EN
        cnt_en = 1;
`else
        cnt_en = 0;
`endif
        reset = 1'b1; start = 1'b0; start_addr = 8'h00; inst = 9'h000;
        cond_flag = 1'b0; rs_value = 8'h00; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_strobes",
                  {init, fetch_unit_en, branch, branchi, jump, reg_we, mem_req, mem_we, busy, done, err}, 0);
        check_val("reset_buses", {start_address, target, immediate, opcode, rd, rs, retired_count}, 0);
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_after_reset", {init, fetch_unit_en, busy, done, err, mem_req}, 0);

        run_inst(9'b001_010_011, 1'b0, 8'h00, 0,  1, 8'h10, 0);  // ADDI
        run_inst(9'b100_001_101, 1'b1, 8'h00, 0,  0, 8'h00, 0);  // BCND taken
        run_inst(9'b100_001_101, 1'b0, 8'h00, 0,  0, 8'h00, 0);  // BCND not taken
        run_inst(9'b101_110_101, 1'b0, 8'h00, 0,  0, 8'h00, 1);  // JMP, start poked while busy
        run_inst(9'b000_111_001, 1'b1, 8'h99, 0,  0, 8'h00, 0);  // ALU
        run_inst(9'b010_001_010, 1'b0, 8'h00, 3,  0, 8'h00, 0);  // LW, ack in 3rd cycle
        run_inst(9'b011_010_100, 1'b0, 8'h00, 1,  0, 8'h00, 0);  // SW, immediate ack
        run_inst(9'b010_100_001, 1'b0, 8'h00, 15, 0, 8'h00, 0);  // LW, ack on timeout cycle
        run_inst(9'b111_000_001, 1'b0, 8'h00, 0,  0, 8'h00, 0);  // NOP
        run_timeout();
        run_inst(9'b110_000_000, 1'b0, 8'h42, 0,  1, 8'h20, 0);  // BR after restart
        run_halt();

        // Reset while waiting in MEM.
        begin
            bit in_mem = 0;
            inst = 9'b010_001_010; start_addr = 8'h30; start = 1'b1;
            for (int i = 1; i <= 20 && !in_mem; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (mem_req) in_mem = 1;
            end
            check_val("reached_mem", in_mem, 1);
            reset = 1'b1;
            @(negedge clk);
            check_val("mem_reset_strobes",
                      {init, fetch_unit_en, branch, branchi, jump, reg_we, mem_req, mem_we, busy, done, err}, 0);
            check_val("mem_reset_buses", {start_address, target, immediate, opcode, rd, rs, retired_count}, 0);
            reset = 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_ack = 1'b1;
                @(negedge clk);
                check_val("idle_ignores_ack", {fetch_unit_en, reg_we, mem_req, busy, init}, 0);
            end
            mem_ack = 1'b0;
            $display("[%0t] reset in MEM", $time);
        end

        check_val("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
